fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage sitting directly upstream of the decode/controller stage.
- Holds the architectural PC and fetches the instruction word from a variable-latency instruction memory using a request/valid handshake.
- Presents a stable Instr to the decoder until the core signals commit.
- On commit, consumes the controller's PCSrc, together with the branch-target and ALU results, to select the next PC.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- PCSrc  in  2  next-PC select from the controller: 00 = PC+4, 01 = PCTarget, 10 = jalr, 11 = reserved.
- PCTarget  in  XLEN  PC+ImmExt from the branch adder.
- ALUResult  in  XLEN  jalr target (rs1+imm).
- Commit  in  1  the current instruction completes this cycle; PCSrc, PCTarget and ALUResult are valid.
- IMemReq  out  1  instruction-memory request.
- IMemAddr  out  XLEN  fetch address; always equals PC.
- IMemValid  in  1  response valid; IMemRData is valid in the same cycle.
- IMemRData  in  32  instruction word.
- PC  out  XLEN  address of the current instruction.
- PCPlus4  out  XLEN  PC+4, combinational, wraps modulo 2^XLEN.
- Instr  out  32  captured instruction.
- InstrValid  out  1  Instr is valid for decode.
- Misaligned  out  1  sticky instruction-address-misaligned flag.
- RetireCount  out  32  number of committed instructions.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - PC=RESET_PC, Instr=32'h0000_0013 (nop), InstrValid=0, Misaligned=0, RetireCount=0.
  - state=FETCH.
  - IMemReq=0 while reset is asserted.
- States:
  - FETCH: IMemReq=1, InstrValid=0.
  - EXEC: IMemReq=0, InstrValid=1.
  - HALT: IMemReq=0, InstrValid=0, Misaligned=1.
- FETCH:
  - IMemReq stays 1 and IMemAddr stays PC until IMemValid=1.
  - When IMemValid=1: Instr<=IMemRData, go to EXEC.
  - Zero-wait memory is permitted (IMemValid in the first request cycle). Minimum fetch-to-EXEC latency is 1 cycle.
  - Commit in FETCH is ignored; PC and RetireCount are unchanged.
- EXEC:
  - Instr and PC are held stable.
  - IMemValid in EXEC is ignored.
  - When Commit=1: compute NextPC, RetireCount<=RetireCount+1 (wraps at 2^32).
    - If NextPC[1:0]==00: PC<=NextPC, go to FETCH. InstrValid drops the next cycle.
    - Otherwise: PC<=NextPC, Misaligned<=1, go to HALT.
- NextPC:
  - 00 → PCPlus4.
  - 01 → PCTarget.
  - 10 → {ALUResult[XLEN-1:1],1'b0} (jalr clears the LSB).
  - 11 → PCPlus4.
- HALT is terminal; only reset exits it. All inputs are ignored in HALT.
- Back-to-back commits are impossible: at least one FETCH cycle separates instructions.
- Throughput with zero-wait memory is 1 instruction per 2 cycles.
- Reset asserted mid-FETCH aborts the request: IMemReq drops immediately (asynchronously). The memory must discard the outstanding request.
- PC wrap: PC=32'hFFFF_FFFC with PCSrc=00 → PC=0, no flag.
- The misalignment check applies only to NextPC bit[1]/bit[0] after the jalr LSB clear. A jalr to an address with bit1=1 flags.

Test Plan:
- Reset/first fetch: release reset with RESET_PC=0. Required: IMemReq=1, IMemAddr=0 in the first cycle; IMemValid with data 32'h00500093 → next cycle Instr=00500093, InstrValid=1.
- Sequential flow with 3-cycle memory latency:
  - Required: IMemReq held high for all 3 wait cycles with IMemAddr stable.
  - Commit with PCSrc=00 at PC=0x10 → PC=0x14, InstrValid=0, RetireCount increments by 1.
- Branch and jalr:
  - PC=0x20, PCSrc=01, PCTarget=0x40 → PC=0x40.
  - PCSrc=10, ALUResult=0x81 → PC=0x80, Misaligned=0.
- Misalignment:
  - PCSrc=01, PCTarget=0x46 → PC=0x46, Misaligned=1, state HALT.
  - Required: IMemReq stays 0 and Commit/IMemValid have no effect for 10 cycles; reset clears Misaligned.
- Ignored events:
  - Commit=1 during FETCH → PC and RetireCount unchanged.
  - IMemValid=1 with a new word during EXEC → Instr unchanged.
- Reset mid-operation:
  - Assert reset between clock edges during a FETCH wait → IMemReq=0 immediately, PC=RESET_PC.
  - After release, fetch restarts at RESET_PC and RetireCount=0.
- PC wrap: PC=0xFFFFFFFC, PCSrc=00, Commit → PC=0x0, Misaligned=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Program-counter and instruction-fetch stage: fetches one word per instruction over a
// request/valid memory handshake and holds it for decode until commit selects the next PC.
module fetch_unit #(
    parameter int unsigned         XLEN     = 32,
    parameter logic [XLEN-1:0]     RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic [XLEN-1:0] ALUResult,
    input  logic            Commit,
    output logic            IMemReq,
    output logic [XLEN-1:0] IMemAddr,
    input  logic            IMemValid,
    input  logic [31:0]     IMemRData,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [31:0]     Instr,
    output logic            InstrValid,
    output logic            Misaligned,
    output logic [31:0]     RetireCount
);

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10
    } state_t;

    state_t          state;
    logic [XLEN-1:0] next_pc;

    assign PCPlus4  = PC + XLEN'(4);
    assign IMemAddr = PC;
    // Gated by reset so an in-flight request is withdrawn the moment reset asserts.
    assign IMemReq    = reset && (state == FETCH);
    assign InstrValid = (state == EXEC);

    always_comb begin
        next_pc = PCPlus4;
        unique case (PCSrc)
            2'b01:   next_pc = PCTarget;
            2'b10:   next_pc = ALUResult & ~XLEN'(1);
            default: next_pc = PCPlus4;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            PC          <= RESET_PC;
            Instr       <= 32'h0000_0013;
            Misaligned  <= 1'b0;
            RetireCount <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (IMemValid) begin
                        Instr <= IMemRData;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (Commit) begin
                        PC          <= next_pc;
                        RetireCount <= RetireCount + 32'd1;
                        if (next_pc[1:0] == 2'b00) begin
                            state <= FETCH;
                        end else begin
                            Misaligned <= 1'b1;
                            state      <= HALT;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard holds the instruction each fetch should
// deliver and a monitor compares whenever InstrValid rises.
module tb_fetch_unit;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [1:0]      PCSrc = 2'b00;
    logic [XLEN-1:0] PCTarget = '0;
    logic [XLEN-1:0] ALUResult = '0;
    logic            Commit = 1'b0;
    logic            IMemReq;
    logic [XLEN-1:0] IMemAddr;
    logic            IMemValid = 1'b0;
    logic [31:0]     IMemRData = '0;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] PCPlus4;
    logic [31:0]     Instr;
    logic            InstrValid;
    logic            Misaligned;
    logic [31:0]     RetireCount;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget),
        .ALUResult(ALUResult), .Commit(Commit), .IMemReq(IMemReq),
        .IMemAddr(IMemAddr), .IMemValid(IMemValid), .IMemRData(IMemRData),
        .PC(PC), .PCPlus4(PCPlus4), .Instr(Instr), .InstrValid(InstrValid),
        .Misaligned(Misaligned), .RetireCount(RetireCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] retire;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_retire = '0;
    logic        prev_v = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: each new instruction presented to decode must match the scoreboard head.
    always @(negedge clk) begin
        if (InstrValid === 1'b1 && prev_v === 1'b0) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=%h required=none", Instr);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_pc", PC, mon_e.pc);
                chk("sb_instr", Instr, mon_e.instr);
                chk("sb_retire", RetireCount, mon_e.retire);
                chk("sb_misaligned", 32'(Misaligned), 32'd0);
            end
        end
        prev_v = InstrValid;
    end

    task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int unsigned waits);
        int unsigned n = 0;
        while (IMemReq !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req_seen", 32'(IMemReq), 32'd1);
        if (IMemReq !== 1'b1) return;
        chk("fetch_addr", IMemAddr, addr);
        for (int unsigned i = 0; i < waits; i++) begin
            @(negedge clk);
            chk("wait_req", 32'(IMemReq), 32'd1);
            chk("wait_addr", IMemAddr, addr);
            chk("wait_instrvalid", 32'(InstrValid), 32'd0);
        end
        IMemValid = 1'b1;
        IMemRData = word;
        sbq.push_back('{addr, word, exp_retire});
        @(negedge clk);
        IMemValid = 1'b0;
        IMemRData = '0;
    endtask

    task automatic commit(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu,
                          input logic [31:0] exp_pc, input logic exp_mis);
        chk("pre_commit_valid", 32'(InstrValid), 32'd1);
        PCSrc     = src;
        PCTarget  = tgt;
        ALUResult = alu;
        Commit    = 1'b1;
        @(negedge clk);
        Commit    = 1'b0;
        PCSrc     = 2'b00;
        exp_retire = exp_retire + 32'd1;
        chk("commit_pc", PC, exp_pc);
        chk("commit_retire", RetireCount, exp_retire);
        chk("commit_misaligned", 32'(Misaligned), 32'(exp_mis));
        chk("commit_instrvalid", 32'(InstrValid), 32'd0);
        chk("commit_req", 32'(IMemReq), 32'(!exp_mis));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_req", 32'(IMemReq), 32'd0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instr, 32'h0000_0013);
        chk("rst_instrvalid", 32'(InstrValid), 32'd0);
        chk("rst_misaligned", 32'(Misaligned), 32'd0);
        chk("rst_retire", RetireCount, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // First fetch, zero-wait
        fetch(32'h0, 32'h0050_0093, 0);
        chk("first_pcplus4", PCPlus4, 32'h4);

        // IMemValid during EXEC is ignored
        IMemValid = 1'b1;
        IMemRData = 32'hDEAD_BEEF;
        @(negedge clk);
        IMemValid = 1'b0;
        IMemRData = '0;
        chk("exec_ignore_instr", Instr, 32'h0050_0093);
        chk("exec_ignore_valid", 32'(InstrValid), 32'd1);

        commit(2'b01, 32'h10, 32'h0, 32'h10, 1'b0);

        // Commit during FETCH is ignored
        PCSrc    = 2'b01;
        PCTarget = 32'h100;
        Commit   = 1'b1;
        @(negedge clk);
        Commit   = 1'b0;
        PCSrc    = 2'b00;
        chk("fetch_commit_pc", PC, 32'h10);
        chk("fetch_commit_retire", RetireCount, 32'd1);

        fetch(32'h10, 32'h00A0_0113, 3);
        commit(2'b00, 32'h0, 32'h0, 32'h14, 1'b0);
        fetch(32'h14, 32'h0020_8193, 1);
        commit(2'b01, 32'h20, 32'h0, 32'h20, 1'b0);
        fetch(32'h20, 32'h0200_0063, 0);
        commit(2'b01, 32'h40, 32'h0, 32'h40, 1'b0);
        fetch(32'h40, 32'h0000_80E7, 0);
        commit(2'b10, 32'h0, 32'h81, 32'h80, 1'b0);
        fetch(32'h80, 32'h1234_5678, 2);
        commit(2'b11, 32'h200, 32'h300, 32'h84, 1'b0);
        fetch(32'h84, 32'h0000_0013, 0);
        commit(2'b01, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 1'b0);
        fetch(32'hFFFF_FFFC, 32'hCAFE_0013, 2);
        chk("wrap_pcplus4", PCPlus4, 32'h0);
        commit(2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
        fetch(32'h0, 32'h0460_006F, 0);
        commit(2'b01, 32'h46, 32'h0, 32'h46, 1'b1);

        // HALT ignores everything
        Commit    = 1'b1;
        PCSrc     = 2'b01;
        PCTarget  = 32'h0;
        IMemValid = 1'b1;
        IMemRData = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_req", 32'(IMemReq), 32'd0);
            chk("halt_pc", PC, 32'h46);
            chk("halt_retire", RetireCount, 32'd9);
            chk("halt_misaligned", 32'(Misaligned), 32'd1);
            chk("halt_instrvalid", 32'(InstrValid), 32'd0);
        end
        chk("halt_instr", Instr, 32'h0460_006F);
        Commit    = 1'b0;
        PCSrc     = 2'b00;
        IMemValid = 1'b0;
        IMemRData = '0;

        // Reset clears HALT
        #2 reset = 1'b0;
        #1;
        chk("halt_rst_misaligned", 32'(Misaligned), 32'd0);
        chk("halt_rst_pc", PC, 32'h0);
        chk("halt_rst_retire", RetireCount, 32'd0);
        chk("halt_rst_instr", Instr, 32'h0000_0013);
        chk("halt_rst_req", 32'(IMemReq), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_retire = '0;
        @(negedge clk);
        fetch(32'h0, 32'h0010_0093, 0);
        commit(2'b01, 32'h30, 32'h0, 32'h30, 1'b0);

        // Reset mid-FETCH wait
        @(negedge clk);
        chk("midrst_pre_req", 32'(IMemReq), 32'd1);
        chk("midrst_pre_addr", IMemAddr, 32'h30);
        #2 reset = 1'b0;
        #1;
        chk("midrst_req", 32'(IMemReq), 32'd0);
        chk("midrst_pc", PC, 32'h0);
        chk("midrst_retire", RetireCount, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_retire = '0;
        @(negedge clk);
        fetch(32'h0, 32'h0030_0193, 1);
        commit(2'b00, 32'h0, 32'h0, 32'h4, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
